// File: rtl/connect4_pkg.sv
// Shared constants and types for the 4x4 Connect-4 move path.
package connect4_pkg;

  localparam int unsigned COLS      = 4;
  localparam int unsigned ROWS      = 4;
  localparam int unsigned NUM_LINES = 10;

  localparam logic [4:0] IDLE_POS   = 5'b11111;
  localparam logic [2:0] COUNT_FULL = 3'(ROWS);

  // Active-low one-hot column buttons
  localparam logic [3:0] COL0_SEL = 4'b1110;
  localparam logic [3:0] COL1_SEL = 4'b1101;
  localparam logic [3:0] COL2_SEL = 4'b1011;
  localparam logic [3:0] COL3_SEL = 4'b0111;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_OVER
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } col_sel_t;

  // Cell index = row*4 + col, row 0 at the bottom
  localparam logic [NUM_LINES-1:0][15:0] WIN_LINES = {
    16'h1248,  // anti-diagonal 3,6,9,12
    16'h8421,  // diagonal 0,5,10,15
    16'h8888,  // column 3
    16'h4444,  // column 2
    16'h2222,  // column 1
    16'h1111,  // column 0
    16'hF000,  // row 3
    16'h0F00,  // row 2
    16'h00F0,  // row 1
    16'h000F   // row 0
  };

  // Map a button pattern to a column index; anything but a single zero is invalid
  function automatic col_sel_t decode_column(input logic [3:0] sel);
    col_sel_t r;
    r.valid = 1'b1;
    r.idx   = 2'd0;
    case (sel)
      COL0_SEL: r.idx = 2'd0;
      COL1_SEL: r.idx = 2'd1;
      COL2_SEL: r.idx = 2'd2;
      COL3_SEL: r.idx = 2'd3;
      default:  r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/connect4_win_detect.sv
// Flags a completed four-in-a-line in one player's occupancy mask.
module connect4_win_detect
  import connect4_pkg::*;
(
  input  logic [15:0] mask,
  output logic        win
);

  // Any line whose cells are all occupied is a win
  always_comb begin
    win = 1'b0;
    for (int unsigned i = 0; i < NUM_LINES; i++) begin
      if ((mask & WIN_LINES[i]) == WIN_LINES[i]) begin
        win = 1'b1;
      end
    end
  end

endmodule

// File: rtl/connect4_move_controller.sv
// Sequences one Connect-4 move: validate, place, evaluate, hand over turn.
module connect4_move_controller
  import connect4_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        new_game,
  input  logic        move_req,
  input  logic [3:0]  selected_column,
  output logic [4:0]  column_position,
  output logic        place_valid,
  output logic        move_reject,
  output logic        move_done,
  output logic        player,
  output logic [2:0]  counter_0,
  output logic [2:0]  counter_1,
  output logic [2:0]  counter_2,
  output logic [2:0]  counter_3,
  output logic [15:0] board_p1,
  output logic [15:0] board_p2,
  output logic        game_over,
  output logic [1:0]  winner
);

  state_t      state;
  logic [2:0]  count [COLS];
  col_sel_t    sel;
  logic [2:0]  tgt_count;
  logic [4:0]  land_pos;
  logic [15:0] land_bit;
  logic        legal;
  logic [15:0] mover_mask;
  logic        mover_win;
  logic        board_full;

  assign counter_0 = count[0];
  assign counter_1 = count[1];
  assign counter_2 = count[2];
  assign counter_3 = count[3];

  // Decode the request and work out where the piece would land
  always_comb begin
    sel        = decode_column(selected_column);
    tgt_count  = count[sel.idx];
    land_pos   = {tgt_count, 2'b00} + {3'b000, sel.idx};
    land_bit   = 16'd1 << land_pos[3:0];
    legal      = sel.valid && (tgt_count != COUNT_FULL) && !game_over;
    mover_mask = player ? board_p2 : board_p1;
    board_full = 1'b1;
    for (int unsigned i = 0; i < COLS; i++) begin
      if (count[i] != COUNT_FULL) begin
        board_full = 1'b0;
      end
    end
  end

  connect4_win_detect u_win_detect (
    .mask (mover_mask),
    .win  (mover_win)
  );

  // Move FSM with registered outputs; new_game mirrors the async reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      column_position <= IDLE_POS;
      place_valid     <= 1'b0;
      move_reject     <= 1'b0;
      move_done       <= 1'b0;
      player          <= 1'b0;
      board_p1        <= '0;
      board_p2        <= '0;
      game_over       <= 1'b0;
      winner          <= WIN_NONE;
      for (int unsigned i = 0; i < COLS; i++) begin
        count[i] <= '0;
      end
    end else begin
      place_valid <= 1'b0;
      move_reject <= 1'b0;
      move_done   <= 1'b0;
      if (new_game) begin
        state           <= ST_IDLE;
        column_position <= IDLE_POS;
        player          <= 1'b0;
        board_p1        <= '0;
        board_p2        <= '0;
        game_over       <= 1'b0;
        winner          <= WIN_NONE;
        for (int unsigned i = 0; i < COLS; i++) begin
          count[i] <= '0;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (move_req) begin
              if (legal) begin
                column_position <= land_pos;
                if (player) begin
                  board_p2 <= board_p2 | land_bit;
                end else begin
                  board_p1 <= board_p1 | land_bit;
                end
                count[sel.idx] <= tgt_count + 3'd1;
                place_valid    <= 1'b1;
                state          <= ST_CHECK;
              end else begin
                move_reject     <= 1'b1;
                column_position <= IDLE_POS;
              end
            end
          end
          ST_CHECK: begin
            column_position <= IDLE_POS;
            move_done       <= 1'b1;
            if (mover_win) begin
              winner    <= player ? WIN_P2 : WIN_P1;
              game_over <= 1'b1;
              state     <= ST_OVER;
            end else if (board_full) begin
              winner    <= WIN_DRAW;
              game_over <= 1'b1;
              state     <= ST_OVER;
            end else begin
              player <= ~player;
              state  <= ST_IDLE;
            end
          end
          ST_OVER: begin
            if (move_req) begin
              move_reject <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_connect4_move_controller.sv
// Directed bench for connect4_move_controller: vector table plus multi-cycle sequences.
module tb_connect4_move_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        new_game;
  logic        move_req;
  logic [3:0]  selected_column;
  logic [4:0]  column_position;
  logic        place_valid;
  logic        move_reject;
  logic        move_done;
  logic        player;
  logic [2:0]  counter_0, counter_1, counter_2, counter_3;
  logic [15:0] board_p1, board_p2;
  logic        game_over;
  logic [1:0]  winner;

  int errors = 0;
  int checks = 0;

  localparam logic [3:0] C0 = 4'b1110;
  localparam logic [3:0] C1 = 4'b1101;
  localparam logic [3:0] C2 = 4'b1011;
  localparam logic [3:0] C3 = 4'b0111;
  localparam logic [3:0] NS = 4'b1111;

  typedef struct {
    logic        ng;
    logic        req;
    logic [3:0]  sel;
    logic        pv;
    logic        rej;
    logic        done;
    logic [4:0]  pos;
    logic        ply;
    logic [11:0] cnt;   // {c3,c2,c1,c0}, one octal digit each
    logic [15:0] p1;
    logic [15:0] p2;
    logic        go;
    logic [1:0]  win;
  } vec_t;

  vec_t vecs[$];

  connect4_move_controller dut (
    .clk             (clk),
    .reset           (reset),
    .new_game        (new_game),
    .move_req        (move_req),
    .selected_column (selected_column),
    .column_position (column_position),
    .place_valid     (place_valid),
    .move_reject     (move_reject),
    .move_done       (move_done),
    .player          (player),
    .counter_0       (counter_0),
    .counter_1       (counter_1),
    .counter_2       (counter_2),
    .counter_3       (counter_3),
    .board_p1        (board_p1),
    .board_p2        (board_p2),
    .game_over       (game_over),
    .winner          (winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic ng, input logic req, input logic [3:0] sel,
                     input logic pv, input logic rej, input logic done,
                     input logic [4:0] pos, input logic ply, input logic [11:0] cnt,
                     input logic [15:0] p1, input logic [15:0] p2,
                     input logic go, input logic [1:0] win);
    vec_t v;
    v.ng = ng; v.req = req; v.sel = sel; v.pv = pv; v.rej = rej; v.done = done;
    v.pos = pos; v.ply = ply; v.cnt = cnt; v.p1 = p1; v.p2 = p2; v.go = go; v.win = win;
    vecs.push_back(v);
  endtask

  task automatic chk_state(input string tag, input logic pv, input logic rej, input logic done,
                           input logic [4:0] pos, input logic ply, input logic [11:0] cnt,
                           input logic [15:0] p1, input logic [15:0] p2,
                           input logic go, input logic [1:0] win);
    chk({tag, "_place_valid"}, 32'(place_valid), 32'(pv));
    chk({tag, "_move_reject"}, 32'(move_reject), 32'(rej));
    chk({tag, "_move_done"}, 32'(move_done), 32'(done));
    chk({tag, "_column_position"}, 32'(column_position), 32'(pos));
    chk({tag, "_player"}, 32'(player), 32'(ply));
    chk({tag, "_counters"}, 32'({counter_3, counter_2, counter_1, counter_0}), 32'(cnt));
    chk({tag, "_board_p1"}, 32'(board_p1), 32'(p1));
    chk({tag, "_board_p2"}, 32'(board_p2), 32'(p2));
    chk({tag, "_game_over"}, 32'(game_over), 32'(go));
    chk({tag, "_winner"}, 32'(winner), 32'(win));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time expired, required finish before 1000000");
    $fatal(1);
  end

  initial begin
    int unsigned pos_seq [16] = '{0, 2, 1, 3, 6, 4, 7, 5, 8, 10, 9, 11, 14, 12, 15, 13};
    logic [1:0] col;

    // ng req sel  pv rej dn pos ply cnt       p1        p2       go win
    // First move and held request during CHECK
    add(0, 1, C0,  1, 0, 0,  0, 0, 12'o0001, 16'h0001, 16'h0000, 0, 2'b00);
    add(0, 1, C0,  0, 0, 1, 31, 1, 12'o0001, 16'h0001, 16'h0000, 0, 2'b00);
    add(0, 0, C0,  0, 0, 0, 31, 1, 12'o0001, 16'h0001, 16'h0000, 0, 2'b00);
    // new_game beats a simultaneous request
    add(1, 1, C1,  0, 0, 0, 31, 0, 12'o0000, 16'h0000, 16'h0000, 0, 2'b00);
    // Column 1 filled by alternating players, then a fifth drop is refused
    add(0, 1, C1,  1, 0, 0,  1, 0, 12'o0010, 16'h0002, 16'h0000, 0, 2'b00);
    add(0, 0, C1,  0, 0, 1, 31, 1, 12'o0010, 16'h0002, 16'h0000, 0, 2'b00);
    add(0, 1, C1,  1, 0, 0,  5, 1, 12'o0020, 16'h0002, 16'h0020, 0, 2'b00);
    add(0, 0, C1,  0, 0, 1, 31, 0, 12'o0020, 16'h0002, 16'h0020, 0, 2'b00);
    add(0, 1, C1,  1, 0, 0,  9, 0, 12'o0030, 16'h0202, 16'h0020, 0, 2'b00);
    add(0, 0, C1,  0, 0, 1, 31, 1, 12'o0030, 16'h0202, 16'h0020, 0, 2'b00);
    add(0, 1, C1,  1, 0, 0, 13, 1, 12'o0040, 16'h0202, 16'h2020, 0, 2'b00);
    add(0, 0, C1,  0, 0, 1, 31, 0, 12'o0040, 16'h0202, 16'h2020, 0, 2'b00);
    add(0, 1, C1,  0, 1, 0, 31, 0, 12'o0040, 16'h0202, 16'h2020, 0, 2'b00);
    add(0, 0, C1,  0, 0, 0, 31, 0, 12'o0040, 16'h0202, 16'h2020, 0, 2'b00);
    add(1, 0, NS,  0, 0, 0, 31, 0, 12'o0000, 16'h0000, 16'h0000, 0, 2'b00);
    // P1 completes row 0 while P2 stacks on row 1
    add(0, 1, C0,  1, 0, 0,  0, 0, 12'o0001, 16'h0001, 16'h0000, 0, 2'b00);
    add(0, 0, C0,  0, 0, 1, 31, 1, 12'o0001, 16'h0001, 16'h0000, 0, 2'b00);
    add(0, 1, C0,  1, 0, 0,  4, 1, 12'o0002, 16'h0001, 16'h0010, 0, 2'b00);
    add(0, 0, C0,  0, 0, 1, 31, 0, 12'o0002, 16'h0001, 16'h0010, 0, 2'b00);
    add(0, 1, C1,  1, 0, 0,  1, 0, 12'o0012, 16'h0003, 16'h0010, 0, 2'b00);
    add(0, 0, C1,  0, 0, 1, 31, 1, 12'o0012, 16'h0003, 16'h0010, 0, 2'b00);
    add(0, 1, C1,  1, 0, 0,  5, 1, 12'o0022, 16'h0003, 16'h0030, 0, 2'b00);
    add(0, 0, C1,  0, 0, 1, 31, 0, 12'o0022, 16'h0003, 16'h0030, 0, 2'b00);
    add(0, 1, C2,  1, 0, 0,  2, 0, 12'o0122, 16'h0007, 16'h0030, 0, 2'b00);
    add(0, 0, C2,  0, 0, 1, 31, 1, 12'o0122, 16'h0007, 16'h0030, 0, 2'b00);
    add(0, 1, C2,  1, 0, 0,  6, 1, 12'o0222, 16'h0007, 16'h0070, 0, 2'b00);
    add(0, 0, C2,  0, 0, 1, 31, 0, 12'o0222, 16'h0007, 16'h0070, 0, 2'b00);
    add(0, 1, C3,  1, 0, 0,  3, 0, 12'o1222, 16'h000F, 16'h0070, 0, 2'b00);
    add(0, 0, C3,  0, 0, 1, 31, 0, 12'o1222, 16'h000F, 16'h0070, 1, 2'b01);
    add(0, 1, C3,  0, 1, 0, 31, 0, 12'o1222, 16'h000F, 16'h0070, 1, 2'b01);
    add(0, 1, C0,  0, 1, 0, 31, 0, 12'o1222, 16'h000F, 16'h0070, 1, 2'b01);
    add(0, 0, C0,  0, 0, 0, 31, 0, 12'o1222, 16'h000F, 16'h0070, 1, 2'b01);
    add(1, 0, NS,  0, 0, 0, 31, 0, 12'o0000, 16'h0000, 16'h0000, 0, 2'b00);
    // Malformed button patterns are refused without touching state
    add(0, 1, 4'b1001, 0, 1, 0, 31, 0, 12'o0000, 16'h0000, 16'h0000, 0, 2'b00);
    add(0, 1, NS,      0, 1, 0, 31, 0, 12'o0000, 16'h0000, 16'h0000, 0, 2'b00);
    add(0, 1, 4'b0000, 0, 1, 0, 31, 0, 12'o0000, 16'h0000, 16'h0000, 0, 2'b00);
    add(0, 0, C0,      0, 0, 0, 31, 0, 12'o0000, 16'h0000, 16'h0000, 0, 2'b00);

    reset = 1'b1;
    new_game = 1'b0;
    move_req = 1'b0;
    selected_column = NS;
    repeat (2) @(negedge clk);
    chk_state("reset", 0, 0, 0, 31, 0, 12'o0000, 16'h0000, 16'h0000, 0, 2'b00);
    reset = 1'b0;

    foreach (vecs[i]) begin
      new_game = vecs[i].ng;
      move_req = vecs[i].req;
      selected_column = vecs[i].sel;
      step();
      chk_state($sformatf("vec%0d", i), vecs[i].pv, vecs[i].rej, vecs[i].done, vecs[i].pos,
                vecs[i].ply, vecs[i].cnt, vecs[i].p1, vecs[i].p2, vecs[i].go, vecs[i].win);
    end
    new_game = 1'b0;
    move_req = 1'b0;

    // Fill the board in an order that never completes a line for either player
    for (int i = 0; i < 16; i++) begin
      col = 2'(pos_seq[i] % 4);
      selected_column = ~(4'b0001 << col);
      move_req = 1'b1;
      step();
      chk($sformatf("draw%0d_place_valid", i), 32'(place_valid), 32'd1);
      chk($sformatf("draw%0d_position", i), 32'(column_position), 32'(pos_seq[i]));
      move_req = 1'b0;
      step();
      chk($sformatf("draw%0d_move_done", i), 32'(move_done), 32'd1);
      if (i < 15) begin
        chk($sformatf("draw%0d_player", i), 32'(player), 32'((i + 1) % 2));
        chk($sformatf("draw%0d_game_over", i), 32'(game_over), 32'd0);
      end else begin
        chk("draw_winner", 32'(winner), 32'd3);
        chk("draw_game_over", 32'(game_over), 32'd1);
        chk("draw_player", 32'(player), 32'd1);
      end
    end
    chk("draw_board_p1", 32'(board_p1), 32'h0000C3C3);
    chk("draw_board_p2", 32'(board_p2), 32'h00003C3C);
    chk("draw_counters", 32'({counter_3, counter_2, counter_1, counter_0}), 32'(12'o4444));
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    chk_state("draw_cleared", 0, 0, 0, 31, 0, 12'o0000, 16'h0000, 16'h0000, 0, 2'b00);

    // Asynchronous reset during CHECK aborts the move
    selected_column = C2;
    move_req = 1'b1;
    step();
    chk("abort_place_valid", 32'(place_valid), 32'd1);
    chk("abort_position", 32'(column_position), 32'd2);
    chk("abort_board_p1", 32'(board_p1), 32'h00000004);
    move_req = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk_state("abort_async", 0, 0, 0, 31, 0, 12'o0000, 16'h0000, 16'h0000, 0, 2'b00);
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("abort_no_move_done", 32'(move_done), 32'd0);
    chk("abort_position_idle", 32'(column_position), 32'd31);
    selected_column = C0;
    move_req = 1'b1;
    step();
    chk("abort_next_place", 32'(place_valid), 32'd1);
    chk("abort_next_position", 32'(column_position), 32'd0);
    move_req = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/connect4_move_controller.md
Name: connect4_move_controller

Overview:
- Sequences one Connect-4 move on the 4x4 board: validates the column request, computes the landing cell, updates the board state, checks for a win or draw, then hands the turn to the other player.
- Sits between the column-select input logic (active-low one-hot buttons) and the display/board-memory path.
- Owns the four per-column fill counters and the two player occupancy masks.
- Cell index = row*4 + col, with row 0 at the bottom.

Parameters:
- COLS, 4, number of board columns (fixed 4; cell encoding depends on it)
- ROWS, 4, number of rows; a column is full when its counter equals ROWS
- IDLE_POS, 5'b11111, column_position value when no cell is being placed

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- new_game  in  1  synchronous clear of board, counters, player, result; priority over move_req
- move_req  in  1  level request; sampled only in IDLE
- selected_column  in  4  active-low one-hot: 1110=col0, 1101=col1, 1011=col2, 0111=col3
- column_position  out  5  index of the cell just placed; IDLE_POS otherwise
- place_valid  out  1  one-cycle pulse when column_position is valid
- move_reject  out  1  one-cycle pulse: illegal pattern, full column, or game over
- move_done  out  1  one-cycle pulse ending an accepted move
- player  out  1  current mover (0 = P1, 1 = P2)
- counter_0..counter_3  out  3 each  pieces in each column, 0..4
- board_p1, board_p2  out  16 each  occupancy masks, bit i = cell i
- game_over  out  1  high from game end until new_game or reset
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw

Behaviour:
- Reset (async) and new_game (sync) produce identical state:
  - state=IDLE
  - counters=0, boards=0, player=0
  - column_position=IDLE_POS
  - all pulses 0, game_over=0, winner=00
- new_game wins over any simultaneous move_req.
- Asserting reset or new_game in CHECK aborts the move: no move_done is issued and the board is cleared.
- FSM states:
  - IDLE: wait for a move.
  - CHECK: evaluate the move just placed.
  - OVER: game finished, hold results.
- IDLE, edge with move_req=1:
  - Legal case: selected_column is one of the four patterns, the target counter != ROWS, and game_over=0.
    - column_position <= counter*4 + col (5-bit arithmetic, max 15).
    - Set that bit in the mover's mask.
    - counter <= counter+1.
    - place_valid=1.
    - Next state: CHECK.
  - Illegal case: any other pattern (including 1111 or multiple zeros) or a full column.
    - move_reject=1 for one cycle.
    - column_position=IDLE_POS; no state change.
- CHECK, next edge:
  - place_valid=0, column_position=IDLE_POS, move_done=1.
  - Win test on the mover's mask only, across 10 lines: 4 rows, 4 columns, 2 diagonals (cells 0,5,10,15 and 3,6,9,12).
  - Win → winner = mover+1, game_over=1, state OVER; player is not toggled.
  - Otherwise, if all counters == 4 → winner=11, game_over=1, state OVER.
  - Otherwise → toggle player, state IDLE.
- OVER: any move_req produces move_reject each cycle it is high; exit only via new_game or reset.
- Latency:
  - Request at edge k → place_valid at edge k (registered, visible in cycle k..k+1).
  - move_done at edge k+1.
  - Next request can be accepted at edge k+2.
- Requester handshake:
  - Hold move_req until move_done or move_reject is seen, then drop it.
  - A request still high in IDLE after move_done is treated as a new move; there is no edge detection inside this block.
- Counters saturate at 4 and never wrap; this is guaranteed by the legality check.

Decomposition:
- Shared package connect4_pkg:
  - COLS, ROWS, IDLE_POS
  - column select pattern constants (COL0_SEL..COL3_SEL)
  - winner encoding (WIN_NONE, WIN_P1, WIN_P2, WIN_DRAW)
  - FSM state enum
  - the 10 win-line masks as 16-bit constants
- One natural sub-module: connect4_win_detect.
  - Combinational; input 16-bit mask, output 1-bit win.
  - ANDs the mask against each line constant.
  - Reusable by the display/AI logic.

Test Plan:
- After reset, req with 1110 → place_valid, column_position=0, counter_0=1, board_p1=0x0001; next cycle move_done=1, player=1.
- Four alternating drops into col1 (1101) → positions 1,5,9,13; the fifth req on 1101 → move_reject, no state change.
- P1 plays cols 0,1,2,3 on row 0 while P2 plays row 1 → after P1's fourth drop, winner=01, game_over=1, player stays 0; a further move_req → move_reject.
- selected_column=1001 or 1111 with move_req → move_reject only; counters and boards unchanged.
- Fill all 16 cells with no line → after the last move_done, winner=11, game_over=1; new_game → all cleared, player=0.
- Assert reset in CHECK (the cycle after place_valid) → no move_done, board_p1=0, counters=0, column_position=11111 immediately.
